// File: rtl/tran_rec_pkg.sv
// tran_rec_pkg: shared types and line constants for the ARQ transmitter.
// Holds FSM state enum, line bit levels and the character framer.
package tran_rec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_ACK,
    DONE
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int BITS_PER_CHAR = 10;

  // Character as shifted out LSB first: start, data[0..7], stop.
  function automatic logic [BITS_PER_CHAR-1:0]
    frame_char(input logic [7:0] b);
    return {STOP_BIT, b, START_BIT};
  endfunction

endpackage

// File: rtl/tran_rec_bit_serializer.sv
// tx_bit_serializer: shifts one framed character onto the line.
// Ports: i_clk, i_rst_n, i_start, i_byte -> o_line, o_char_done.
module tx_bit_serializer
  import tran_rec_pkg::*;
#(
  parameter int BIT_CYCLES = 868
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_line,
  output logic       o_char_done
);

  localparam int CW =
    (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST =
    CW'(BIT_CYCLES - 1);
  localparam logic [3:0] BIT_LAST =
    4'(BITS_PER_CHAR - 1);

  logic                     r_active;
  logic [CW-1:0]            r_cyc;
  logic [3:0]               r_bit;
  logic [BITS_PER_CHAR-1:0] r_shift;
  logic                     w_bit_end;

  assign w_bit_end = r_active && (r_cyc == CYC_LAST);
  assign o_char_done = w_bit_end && (r_bit == BIT_LAST);
  // Line is combinational from state so reset idles it at once.
  assign o_line = r_active ? r_shift[0] : LINE_IDLE;

  // A start in the char_done cycle reloads with no gap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= 1'b0;
      r_cyc    <= '0;
      r_bit    <= '0;
      r_shift  <= {BITS_PER_CHAR{LINE_IDLE}};
    end else if (i_start) begin
      r_active <= 1'b1;
      r_cyc    <= '0;
      r_bit    <= '0;
      r_shift  <= frame_char(i_byte);
    end else if (r_active) begin
      if (w_bit_end) begin
        r_cyc <= '0;
        if (r_bit == BIT_LAST) begin
          r_active <= 1'b0;
        end else begin
          r_bit   <= r_bit + 4'd1;
          r_shift <= {LINE_IDLE,
                      r_shift[BITS_PER_CHAR-1:1]};
        end
      end else begin
        r_cyc <= r_cyc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tran_rec.sv
// tran_rec: buffers one frame, serializes it, waits for ACK and retries.
// Ports: frame in (data/valid/last/ready), i_arq_en, line out, ACK in, status pulses.
module tran_rec
  import tran_rec_pkg::*;
#(
  parameter int FRAME_BYTES = 64,
  parameter int BIT_CYCLES  = 868,
  parameter int ACK_TIMEOUT = 2000000,
  parameter int MAX_RETRIES = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_frame_data,
  input  logic       i_frame_data_valid,
  input  logic       i_frame_data_last,
  output logic       o_frame_data_ready,
  input  logic       i_arq_en,
  output logic       o_otn_tx_data,
  input  logic       i_otn_rx_ack,
  output logic       o_frame_done,
  output logic       o_frame_drop,
  output logic       o_retx,
  output logic [1:0] o_retry_cnt,
  output logic       o_busy
);

  localparam int AW = $clog2(FRAME_BYTES);
  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [AW-1:0] ADDR_LAST =
    AW'(FRAME_BYTES - 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'(ACK_TIMEOUT - 1);
  localparam logic [1:0] RETRY_MAX =
    2'(MAX_RETRIES);

  logic          r_rst_meta;
  logic          r_rst_sync;
  logic          w_rst_n;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [7:0]    r_buf [FRAME_BYTES];
  logic [AW-1:0] r_wr_addr;
  logic [AW-1:0] r_last_addr;
  logic [AW-1:0] r_rd_addr;
  logic [AW-1:0] w_rd_addr;
  logic [7:0]    w_ser_byte;

  logic          r_arq;
  logic          r_drop;
  logic [1:0]    r_retry;
  logic [TW-1:0] r_to_cnt;

  logic          r_ack_s1;
  logic          r_ack_s2;
  logic          r_ack_s3;
  logic          w_ack_edge;

  logic          w_accept;
  logic          w_final;
  logic          w_timeout;
  logic          w_ser_start;
  logic          w_char_done;
  logic          w_retx;
  logic          w_set_drop;

  // Async assert, release aligned to i_clk.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ack_s1 <= 1'b0;
      r_ack_s2 <= 1'b0;
      r_ack_s3 <= 1'b0;
    end else begin
      r_ack_s1 <= i_otn_rx_ack;
      r_ack_s2 <= r_ack_s1;
      r_ack_s3 <= r_ack_s2;
    end
  end

  assign w_ack_edge = r_ack_s2 && !r_ack_s3;

  assign w_accept = i_frame_data_valid &&
                    o_frame_data_ready;
  assign w_final  = w_accept &&
                    (i_frame_data_last ||
                     (r_wr_addr == ADDR_LAST));
  assign w_timeout = (r_state == WAIT_ACK) &&
                     (r_to_cnt == TO_LAST);

  // Single-byte frame starts from the input bypass.
  assign w_ser_byte = (r_state == IDLE) ?
                      i_frame_data : r_buf[w_rd_addr];

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_buf[r_wr_addr] <= i_frame_data;
    end
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_ser_start        = 1'b0;
    w_rd_addr          = '0;
    w_retx             = 1'b0;
    w_set_drop         = 1'b0;
    o_frame_data_ready = 1'b0;
    o_busy             = 1'b1;
    o_frame_done       = 1'b0;
    o_frame_drop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        o_frame_data_ready = 1'b1;
        o_busy             = 1'b0;
        if (w_final) begin
          w_state_nxt = SEND;
          w_ser_start = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        o_frame_data_ready = 1'b1;
        o_busy             = 1'b0;
        if (w_final) begin
          w_state_nxt = SEND;
          w_ser_start = 1'b1;
        end
      end
      SEND: begin
        if (w_char_done) begin
          if (r_rd_addr == r_last_addr) begin
            w_state_nxt = r_arq ? WAIT_ACK : DONE;
          end else begin
            w_ser_start = 1'b1;
            w_rd_addr   = r_rd_addr + 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        // ACK beats a simultaneous timeout.
        if (w_ack_edge) begin
          w_state_nxt = DONE;
        end else if (w_timeout) begin
          if (r_retry < RETRY_MAX) begin
            w_state_nxt = SEND;
            w_ser_start = 1'b1;
            w_retx      = 1'b1;
          end else begin
            w_state_nxt = DONE;
            w_set_drop  = 1'b1;
          end
        end
      end
      DONE: begin
        w_state_nxt  = IDLE;
        o_frame_done = !r_drop;
        o_frame_drop = r_drop;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_addr   <= '0;
      r_last_addr <= '0;
      r_rd_addr   <= '0;
      r_arq       <= 1'b0;
      r_drop      <= 1'b0;
      r_retry     <= '0;
      r_to_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_wr_addr <= w_final ? '0 : r_wr_addr + 1'b1;
      end
      if (w_final) begin
        r_last_addr <= r_wr_addr;
      end
      if (w_accept && (r_state == IDLE)) begin
        r_arq   <= i_arq_en;
        r_retry <= '0;
        r_drop  <= 1'b0;
      end
      if (w_ser_start) begin
        r_rd_addr <= w_rd_addr;
      end
      if (w_retx) begin
        r_retry <= r_retry + 2'd1;
      end
      if (w_set_drop) begin
        r_drop <= 1'b1;
      end
      // Zero outside WAIT_ACK, so each wait starts at 0.
      if ((r_state == WAIT_ACK) && !w_timeout) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign o_retx      = w_retx;
  assign o_retry_cnt = r_retry;

  tx_bit_serializer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_ser (
    .i_clk       (i_clk),
    .i_rst_n     (w_rst_n),
    .i_start     (w_ser_start),
    .i_byte      (w_ser_byte),
    .o_line      (o_otn_tx_data),
    .o_char_done (w_char_done)
  );

endmodule

// File: tb/tb_tran_rec.sv
// tb_tran_rec: directed bench for tran_rec with short bit periods.
// Tasks per scenario, inline comparisons, one summary line.
module tb_tran_rec;

  localparam int BC = 4;
  localparam int FB = 8;
  localparam int AT = 100;
  localparam int MR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_frame_data = 8'h00;
  logic       i_frame_data_valid = 1'b0;
  logic       i_frame_data_last = 1'b0;
  logic       o_frame_data_ready;
  logic       i_arq_en = 1'b0;
  logic       o_otn_tx_data;
  logic       i_otn_rx_ack = 1'b0;
  logic       o_frame_done;
  logic       o_frame_drop;
  logic       o_retx;
  logic [1:0] o_retry_cnt;
  logic       o_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  int drop_seen = 0;
  int retx_seen = 0;

  logic [7:0] fr [16];

  tran_rec #(
    .FRAME_BYTES (FB),
    .BIT_CYCLES  (BC),
    .ACK_TIMEOUT (AT),
    .MAX_RETRIES (MR)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_frame_data       (i_frame_data),
    .i_frame_data_valid (i_frame_data_valid),
    .i_frame_data_last  (i_frame_data_last),
    .o_frame_data_ready (o_frame_data_ready),
    .i_arq_en           (i_arq_en),
    .o_otn_tx_data      (o_otn_tx_data),
    .i_otn_rx_ack       (i_otn_rx_ack),
    .o_frame_done       (o_frame_done),
    .o_frame_drop       (o_frame_drop),
    .o_retx             (o_retx),
    .o_retry_cnt        (o_retry_cnt),
    .o_busy             (o_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_frame_done) done_seen++;
    if (o_frame_drop) drop_seen++;
    if (o_retx) retx_seen++;
  end

  function automatic logic [39:0] char_wave(
    input logic [7:0] b);
    logic [9:0] pat;
    logic [39:0] w;
    pat = {1'b1, b, 1'b0};
    for (int k = 0; k < 40; k++) w[k] = pat[k/BC];
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic capture_char(output logic [39:0] obs);
    for (int k = 0; k < 40; k++) begin
      obs[k] = o_otn_tx_data;
      tick(1);
    end
  endtask

  task automatic drive_frame(input int n, input logic arq);
    for (int i = 0; i < n; i++) begin
      i_frame_data       = fr[i];
      i_frame_data_last  = (i == n - 1);
      i_frame_data_valid = 1'b1;
      i_arq_en           = arq;
      tick(1);
    end
    i_frame_data_valid = 1'b0;
    i_frame_data_last  = 1'b0;
  endtask

  task automatic test_reset;
    int d0;
    tick(3);
    n_cmp++;
    if ({o_otn_tx_data, o_frame_data_ready, o_busy,
         o_retry_cnt, o_frame_done, o_frame_drop,
         o_retx} !== 8'b1_1_0_00_000) begin
      n_bad++;
      $display("FAIL reset_state got %b%b%b%b%b%b%b",
               o_otn_tx_data, o_frame_data_ready, o_busy,
               o_retry_cnt, o_frame_done, o_frame_drop,
               o_retx);
    end
    rst_n = 1'b1;
    tick(2);
    fr[0] = 8'hFF;
    drive_frame(1, 1'b0);
    tick(2);
    n_cmp++;
    if (o_otn_tx_data !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pre_start line=%b want 0",
               o_otn_tx_data);
    end
    d0 = done_seen;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_otn_tx_data, o_busy, o_frame_data_ready}
        !== 3'b101) begin
      n_bad++;
      $display("FAIL reset_abort line/busy/ready=%b%b%b want 101",
               o_otn_tx_data, o_busy, o_frame_data_ready);
    end
    tick(2);
    rst_n = 1'b1;
    tick(50);
    n_cmp++;
    if ({o_otn_tx_data, o_busy, o_frame_data_ready,
         done_seen - d0} !== {3'b101, 32'd0}) begin
      n_bad++;
      $display("FAIL reset_idle line/busy/ready=%b%b%b dones=%0d want 101 0",
               o_otn_tx_data, o_busy, o_frame_data_ready,
               done_seen - d0);
    end
  endtask

  task automatic test_arq_off;
    logic [39:0] obs;
    fr[0] = 8'hA5;
    fr[1] = 8'h3C;
    drive_frame(2, 1'b0);
    for (int c = 0; c < 2; c++) begin
      capture_char(obs);
      n_cmp++;
      if (obs !== char_wave(fr[c])) begin
        n_bad++;
        $display("FAIL arq_off_char%0d line=%h want %h",
                 c, obs, char_wave(fr[c]));
      end
    end
    n_cmp++;
    if ({o_frame_done, o_frame_drop} !== 2'b10) begin
      n_bad++;
      $display("FAIL arq_off_done done/drop=%b%b want 10",
               o_frame_done, o_frame_drop);
    end
    tick(1);
    n_cmp++;
    if ({o_frame_done, o_frame_data_ready, o_busy}
        !== 3'b010) begin
      n_bad++;
      $display("FAIL arq_off_after done/ready/busy=%b%b%b want 010",
               o_frame_done, o_frame_data_ready, o_busy);
    end
  endtask

  task automatic test_ack;
    logic [39:0] obs;
    int d0;
    int r0;
    fr[0] = 8'h11;
    fr[1] = 8'h22;
    fr[2] = 8'h33;
    d0 = done_seen;
    r0 = retx_seen;
    drive_frame(3, 1'b1);
    fork
      begin
        for (int c = 0; c < 3; c++) begin
          capture_char(obs);
          n_cmp++;
          if (obs !== char_wave(fr[c])) begin
            n_bad++;
            $display("FAIL ack_char%0d line=%h want %h",
                     c, obs, char_wave(fr[c]));
          end
        end
      end
      begin
        tick(10);
        i_otn_rx_ack = 1'b1;
        tick(4);
        i_otn_rx_ack = 1'b0;
      end
    join
    n_cmp++;
    if ({o_busy, done_seen - d0} !== {1'b1, 32'd0}) begin
      n_bad++;
      $display("FAIL ack_wait_entry busy=%b dones=%0d want 1 0",
               o_busy, done_seen - d0);
    end
    tick(20);
    i_otn_rx_ack = 1'b1;
    tick(2);
    n_cmp++;
    if (o_frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL ack_early done=%b want 0",
               o_frame_done);
    end
    tick(1);
    n_cmp++;
    if ({o_frame_done, o_frame_drop, o_retry_cnt}
        !== 4'b10_00) begin
      n_bad++;
      $display("FAIL ack_done done/drop/retry=%b%b%0d want 1 0 0",
               o_frame_done, o_frame_drop, o_retry_cnt);
    end
    i_otn_rx_ack = 1'b0;
    tick(1);
    n_cmp++;
    if ({done_seen - d0, retx_seen - r0}
        !== {32'd1, 32'd0}) begin
      n_bad++;
      $display("FAIL ack_pulses dones=%0d retx=%0d want 1 0",
               done_seen - d0, retx_seen - r0);
    end
  endtask

  task automatic test_no_ack;
    logic [39:0] obs;
    int r0;
    int p0;
    r0 = retx_seen;
    p0 = drop_seen;
    fr[0] = 8'h5A;
    drive_frame(1, 1'b1);
    for (int s = 0; s < 3; s++) begin
      capture_char(obs);
      n_cmp++;
      if (obs !== char_wave(fr[0])) begin
        n_bad++;
        $display("FAIL no_ack_send%0d line=%h want %h",
                 s, obs, char_wave(fr[0]));
      end
      tick(99);
      if (s < 2) begin
        n_cmp++;
        if ({o_retx, o_retry_cnt} !== {1'b1, 2'(s)}) begin
          n_bad++;
          $display("FAIL no_ack_retx%0d retx/retry=%b/%0d want 1/%0d",
                   s, o_retx, o_retry_cnt, s);
        end
        tick(1);
      end
    end
    n_cmp++;
    if ({o_retx, o_retry_cnt} !== 3'b0_10) begin
      n_bad++;
      $display("FAIL no_ack_last_to retx/retry=%b/%0d want 0/2",
               o_retx, o_retry_cnt);
    end
    tick(1);
    n_cmp++;
    if ({o_frame_drop, o_frame_done, o_retry_cnt}
        !== 4'b10_10) begin
      n_bad++;
      $display("FAIL no_ack_drop drop/done/retry=%b%b%0d want 1 0 2",
               o_frame_drop, o_frame_done, o_retry_cnt);
    end
    tick(1);
    n_cmp++;
    if ({retx_seen - r0, drop_seen - p0, o_retry_cnt,
         o_frame_data_ready}
        !== {32'd2, 32'd1, 2'd2, 1'b1}) begin
      n_bad++;
      $display("FAIL no_ack_totals retx=%0d drops=%0d retry=%0d ready=%b want 2 1 2 1",
               retx_seen - r0, drop_seen - p0, o_retry_cnt,
               o_frame_data_ready);
    end
  endtask

  task automatic test_ack_at_timeout;
    logic [39:0] obs;
    int p0;
    p0 = drop_seen;
    fr[0] = 8'hC3;
    drive_frame(1, 1'b1);
    capture_char(obs);
    n_cmp++;
    if (obs !== char_wave(fr[0])) begin
      n_bad++;
      $display("FAIL coinc_char line=%h want %h",
               obs, char_wave(fr[0]));
    end
    tick(99);
    n_cmp++;
    if (o_retx !== 1'b1) begin
      n_bad++;
      $display("FAIL coinc_first_retx retx=%b want 1",
               o_retx);
    end
    tick(138);
    i_otn_rx_ack = 1'b1;
    tick(2);
    n_cmp++;
    if ({o_retx, o_frame_done} !== 2'b00) begin
      n_bad++;
      $display("FAIL coinc_edge retx/done=%b%b want 00",
               o_retx, o_frame_done);
    end
    tick(1);
    n_cmp++;
    if ({o_frame_done, o_frame_drop, o_retry_cnt}
        !== 4'b10_01) begin
      n_bad++;
      $display("FAIL coinc_done done/drop/retry=%b%b%0d want 1 0 1",
               o_frame_done, o_frame_drop, o_retry_cnt);
    end
    i_otn_rx_ack = 1'b0;
    tick(1);
    n_cmp++;
    if ({drop_seen - p0, o_retry_cnt} !== {32'd0, 2'd1}) begin
      n_bad++;
      $display("FAIL coinc_hold drops=%0d retry=%0d want 0 1",
               drop_seen - p0, o_retry_cnt);
    end
  endtask

  task automatic test_forced_last;
    logic [39:0] obs;
    i_arq_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fr[i] = 8'h10 + 8'(i * 17);
      i_frame_data       = fr[i];
      i_frame_data_last  = 1'b0;
      i_frame_data_valid = 1'b1;
      tick(1);
      if (i == 0) begin
        n_cmp++;
        if (o_retry_cnt !== 2'd0) begin
          n_bad++;
          $display("FAIL forced_retry_clear retry=%0d want 0",
                   o_retry_cnt);
        end
      end
    end
    i_frame_data      = 8'h99;
    i_frame_data_last = 1'b1;
    n_cmp++;
    if ({o_frame_data_ready, o_busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL forced_ready ready/busy=%b%b want 01",
               o_frame_data_ready, o_busy);
    end
    for (int c = 0; c < 8; c++) begin
      capture_char(obs);
      n_cmp++;
      if (obs !== char_wave(fr[c])) begin
        n_bad++;
        $display("FAIL forced_char%0d line=%h want %h",
                 c, obs, char_wave(fr[c]));
      end
    end
    n_cmp++;
    if ({o_frame_done, o_frame_data_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL forced_done done/ready=%b%b want 10",
               o_frame_done, o_frame_data_ready);
    end
    tick(1);
    n_cmp++;
    if (o_frame_data_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL forced_ready_again ready=%b want 1",
               o_frame_data_ready);
    end
    tick(1);
    i_frame_data_valid = 1'b0;
    i_frame_data_last  = 1'b0;
    fr[0] = 8'h99;
    capture_char(obs);
    n_cmp++;
    if (obs !== char_wave(fr[0])) begin
      n_bad++;
      $display("FAIL forced_ninth line=%h want %h",
               obs, char_wave(fr[0]));
    end
    n_cmp++;
    if (o_frame_done !== 1'b1) begin
      n_bad++;
      $display("FAIL forced_ninth_done done=%b want 1",
               o_frame_done);
    end
    tick(1);
  endtask

  initial begin
    test_reset();
    test_arq_off();
    test_ack();
    test_no_ack();
    test_ack_at_timeout();
    test_forced_last();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
